// File: rtl/color_sequence_player.sv
// Plays a colour sequence fetched from RAM as timed one-hot lamp pulses,
// with a direct-show mode for press feedback while idle.
module color_sequence_player #(
  parameter int NUM_COLORS = 4,
  parameter int COLOR_W    = 2,
  parameter int ADDR_W     = 4,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int CNT_W      = 25
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_W:0]       seq_len,
  input  logic                  abort,
  input  logic                  show_en,
  input  logic [COLOR_W-1:0]    show_color,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [COLOR_W-1:0]    rd_data,
  output logic [NUM_COLORS-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     step_idx
);

  localparam int               MAX_LEN  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [NUM_COLORS-1:0] out_q, out_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Out-of-range colour indices decode to no lamp, so the bus is never multi-hot.
  function automatic logic [NUM_COLORS-1:0] onehot(input logic [COLOR_W-1:0] c);
    logic [NUM_COLORS-1:0] o;
    o = '0;
    for (int i = 0; i < NUM_COLORS; i++) begin
      if (int'(c) == i) o[i] = 1'b1;
    end
    return o;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    timer_d   = timer_q;
    out_d     = out_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          out_d = '0;
          if (seq_len != '0) begin
            len_d     = (int'(seq_len) > MAX_LEN) ? (ADDR_W+1)'(MAX_LEN) : seq_len;
            idx_d     = '0;
            rd_addr_d = '0;
            rd_en_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          out_d = show_en ? onehot(show_color) : '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        out_d   = onehot(rd_data);
        timer_d = ON_LOAD;
        state_d = S_ON;
      end
      S_ON: begin
        if (timer_q == '0) begin
          out_d   = '0;
          timer_d = OFF_LOAD;
          state_d = S_OFF;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      S_OFF: begin
        if (timer_q == '0) begin
          if ({1'b0, idx_q} == len_q - LEN_ONE) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + IDX_ONE;
            rd_addr_d = idx_q + IDX_ONE;
            rd_en_d   = 1'b1;
            state_d   = S_FETCH;
          end
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a timer reaching zero this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      out_d   = '0;
      rd_en_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      timer_q   <= '0;
      out_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      timer_q   <= timer_d;
      out_q     <= out_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out      = out_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

// File: tb/tb_color_sequence_player.sv
// Scoreboard bench for color_sequence_player: stimulus pushes expected fetches,
// lamp runs and done pulses; a negedge monitor pops and compares them.
module tb_color_sequence_player;

  localparam int NC   = 4;
  localparam int CW   = 3;
  localparam int AW   = 4;
  localparam int ONC  = 4;
  localparam int OFFC = 2;
  localparam int STEP = ONC + OFFC + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   seq_len = '0;
  logic          abort = 1'b0;
  logic          show_en = 1'b0;
  logic [CW-1:0] show_color = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data = '0;
  logic [NC-1:0] out;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;

  color_sequence_player #(
    .NUM_COLORS(NC), .COLOR_W(CW), .ADDR_W(AW),
    .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .CNT_W(4)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .seq_len(seq_len),
    .abort(abort), .show_en(show_en), .show_color(show_color),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out(out), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] mem [0:15];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    logic [NC-1:0] v;
    int            n;
  } lamp_t;

  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] exp_addr [$];
  lamp_t         exp_lamp [$];
  logic [AW-1:0] exp_done [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: every negedge, compare whatever the DUT presents.
  int            cyc = 0;
  int            last_rd = -1;
  logic [NC-1:0] prev_out = '0;
  int            run_len = 0;
  always @(negedge clk) begin
    cyc++;
    if (!busy) last_rd = -1;
    if (rd_en) begin
      if (exp_addr.size() == 0) flag("unexpected_rd_en");
      else chk("rd_addr", 32'(rd_addr), 32'(exp_addr.pop_front()));
      if (last_rd >= 0) chk("step_period", 32'(cyc - last_rd), 32'(STEP));
      last_rd = cyc;
    end
    if ($countones(out) > 1) flag("out_multi_hot");
    if (out !== prev_out) begin
      if (prev_out != '0) begin
        if (exp_lamp.size() == 0) flag("unexpected_lamp_run");
        else begin
          lamp_t e;
          e = exp_lamp.pop_front();
          chk("lamp_value", 32'(prev_out), 32'(e.v));
          chk("lamp_length", 32'(run_len), 32'(e.n));
        end
      end
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_out = out;
    if (done) begin
      if (exp_done.size() == 0) flag("unexpected_done");
      else chk("done_step_idx", 32'(step_idx), 32'(exp_done.pop_front()));
    end
  end

  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    start = 1'b1;
    seq_len = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done) flag("done_timeout");
    else chk("busy_low_with_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_out(input logic [NC-1:0] v, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (out !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (out !== v) flag("wait_out_timeout");
  endtask

  task automatic push_lamp(input logic [NC-1:0] v, input int n);
    lamp_t e;
    e.v = v;
    e.n = n;
    exp_lamp.push_back(e);
  endtask

  initial begin
    mem[0] = 3'd2; mem[1] = 3'd0; mem[2] = 3'd3; mem[3] = 3'd1;
    for (int i = 4; i < 16; i++) mem[i] = CW'(i % 4);

    // Reset state
    #12;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_step_idx", 32'(step_idx), 32'd0);
    #10 resetn = 1'b1;

    // Basic playback of three steps
    for (int i = 0; i < 3; i++) exp_addr.push_back(AW'(i));
    push_lamp(4'b0100, ONC); push_lamp(4'b0001, ONC); push_lamp(4'b1000, ONC);
    exp_done.push_back(AW'(2));
    pulse_start(3);
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(100);

    // Zero-length sequence: done next cycle only, no lamps, no fetch
    exp_done.push_back(AW'(2));
    @(posedge clk); #1;
    start = 1'b1; seq_len = '0;
    @(negedge clk);
    chk("zero_len_done_first", 32'(done), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_len_done", 32'(done), 32'd1);
    chk("zero_len_out", 32'(out), 32'd0);
    @(negedge clk);
    chk("zero_len_done_once", 32'(done), 32'd0);

    // Over-length request clamps to 16 steps
    for (int i = 0; i < 16; i++) begin
      exp_addr.push_back(AW'(i));
      push_lamp(NC'(1) << mem[i], ONC);
    end
    exp_done.push_back(AW'(15));
    pulse_start(20);
    wait_done(300);

    // Abort during ON of step 1, then replay from step 0
    exp_addr.push_back(AW'(0)); exp_addr.push_back(AW'(1));
    push_lamp(4'b0100, ONC); push_lamp(4'b0001, 2);
    pulse_start(3);
    wait_out(4'b0001, 50);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    exp_addr.push_back(AW'(0));
    push_lamp(4'b0100, ONC);
    exp_done.push_back(AW'(0));
    pulse_start(1);
    @(negedge clk);
    chk("replay_step_idx", 32'(step_idx), 32'd0);
    wait_done(50);

    // Direct show mode in IDLE
    @(posedge clk); #1;
    show_color = 3'd3; show_en = 1'b1;
    push_lamp(4'b1000, 3);
    @(negedge clk);
    chk("show_latency", 32'(out), 32'd0);
    @(negedge clk);
    chk("show_lit", 32'(out), 32'b1000);
    @(posedge clk);
    @(posedge clk); #1;
    show_en = 1'b0;
    @(posedge clk); #1;
    show_color = 3'd5; show_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("show_out_of_range", 32'(out), 32'd0);

    // show_en held through a playback has no effect
    @(posedge clk); #1;
    show_color = 3'd3;
    exp_addr.push_back(AW'(0));
    push_lamp(4'b0100, ONC);
    exp_done.push_back(AW'(0));
    start = 1'b1; seq_len = (AW+1)'(1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    show_en = 1'b0;

    // Async reset mid-ON clears outputs immediately
    exp_addr.push_back(AW'(0));
    push_lamp(4'b0100, 1);
    pulse_start(3);
    wait_out(4'b0100, 20);
    #2 resetn = 1'b0;
    #1;
    chk("areset_out", 32'(out), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_rd_en", 32'(rd_en), 32'd0);
    chk("areset_step_idx", 32'(step_idx), 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;

    // Out-of-range RAM colour: dark step, timing kept
    mem[1] = 3'd5;
    for (int i = 0; i < 3; i++) exp_addr.push_back(AW'(i));
    push_lamp(4'b0100, ONC); push_lamp(4'b1000, ONC);
    exp_done.push_back(AW'(2));
    pulse_start(3);
    wait_done(100);

    repeat (5) @(negedge clk);
    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("lamp_queue_empty", 32'(exp_lamp.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
